// File: rtl/imem_program_loader.sv
// imem_program_loader: streams a program into cpu instruction memory, holding the cpu in reset until it settles
module imem_program_loader #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic                       initialize,
  output logic [DATA_W-1:0]          instruction_initialize_data,
  output logic [ADDR_W-1:0]          instruction_initialize_address,
  output logic                       cpu_rst,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(DEPTH+1)-1:0] word_count,
  output logic [DATA_W-1:0]          checksum
);
  localparam int unsigned CW    = $clog2(DEPTH+1);
  localparam int unsigned DLY_W = RELEASE_DLY > 1 ? $clog2(RELEASE_DLY) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, ERROR} state_t;
  state_t              state_q;
  logic                init_q, cpu_rst_q, done_q, err_q, beat;
  logic [DATA_W-1:0]   data_q, sum_q, sum_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DLY_W-1:0]    dly_q;
  assign s_ready    = state_q == LOAD;
  assign busy       = state_q == LOAD || state_q == SETTLE;
  assign initialize = init_q;
  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign error      = err_q;
  assign word_count = count_q;
  assign checksum   = sum_q;
  always_comb begin
    beat    = s_valid & s_ready;
    addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(count_q) * ADDR_W'(DATA_W / 8);
    count_d = count_q + CW'(1);
    sum_d   = sum_q + s_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      init_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      dly_q     <= '0;
    end else begin
      init_q <= 1'b0;
      case (state_q)
        IDLE, RUN, ERROR: if (start) begin
          state_q   <= LOAD;
          cpu_rst_q <= 1'b1;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
          count_q   <= '0;
          sum_q     <= '0;
        end
        LOAD: if (beat) begin
          init_q  <= 1'b1;
          data_q  <= s_data;
          addr_q  <= addr_d;
          count_q <= count_d;
          sum_q   <= sum_d;
          dly_q   <= '0;
          if (s_last) state_q <= SETTLE;
          else if (count_q == CW'(DEPTH - 1)) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end
        end
        // the first SETTLE cycle is the one showing the final write
        SETTLE: if (dly_q == DLY_W'(RELEASE_DLY - 1)) begin
          state_q   <= RUN;
          cpu_rst_q <= 1'b0;
          done_q    <= 1'b1;
        end else dly_q <= dly_q + DLY_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: scenario table plus random loads checked against a write-log reference model
module tb_imem_program_loader;
  typedef struct {
    bit b; int n; int mode; bit gap; bit last;
    bit chk_tab; int exp_cnt; bit exp_err; logic [31:0] exp_sum; bit chk_sum;
  } scen_t;
  typedef struct { int c; logic [31:0] a; logic [31:0] d; } wr_t;
  logic clk = 0, rst = 1, start_a = 0, start_b = 0, s_valid = 0, s_last = 0, sel = 0;
  logic [31:0] s_data = 0;
  logic rdy_a, init_a, cr_a, busy_a, done_a, err_a;
  logic rdy_b, init_b, cr_b, busy_b, done_b, err_b;
  logic [31:0] d_a, ad_a, sum_a, d_b, ad_b, sum_b;
  logic [6:0] cnt_a;
  logic [2:0] cnt_b;
  logic rdy_m, init_m, cr_m, busy_m, done_m, err_m;
  logic [31:0] d_m, ad_m, sum_m, cnt_m;
  int cyc = 0, checks = 0, failures = 0;
  wr_t log_q[$];
  int fall_q[$];
  logic prev_cr = 1'b1;
  scen_t tab[8];

  imem_program_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(0), .RELEASE_DLY(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(rdy_a), .initialize(init_a), .instruction_initialize_data(d_a),
    .instruction_initialize_address(ad_a), .cpu_rst(cr_a), .busy(busy_a), .done(done_a),
    .error(err_a), .word_count(cnt_a), .checksum(sum_a));
  imem_program_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .BASE_ADDR(0), .RELEASE_DLY(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(rdy_b), .initialize(init_b), .instruction_initialize_data(d_b),
    .instruction_initialize_address(ad_b), .cpu_rst(cr_b), .busy(busy_b), .done(done_b),
    .error(err_b), .word_count(cnt_b), .checksum(sum_b));

  assign rdy_m  = sel ? rdy_b  : rdy_a;
  assign init_m = sel ? init_b : init_a;
  assign cr_m   = sel ? cr_b   : cr_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign err_m  = sel ? err_b  : err_a;
  assign d_m    = sel ? d_b    : d_a;
  assign ad_m   = sel ? ad_b   : ad_a;
  assign sum_m  = sel ? sum_b  : sum_a;
  assign cnt_m  = sel ? 32'(cnt_b) : 32'(cnt_a);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (init_m) log_q.push_back('{cyc, ad_m, d_m});
    if (prev_cr && !cr_m) fall_q.push_back(cyc);
    prev_cr <= cr_m;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_case(input scen_t sc);
    logic [31:0] w[$];
    logic [31:0] exp_sum = '0;
    int depth = sc.b ? 4 : 64;
    int rd = sc.b ? 2 : 4;
    bit ovf = !sc.last || sc.n > depth;
    int acc = ovf ? depth : sc.n;
    int i = 0, cycles = 0, base_w, base_f, n_wr, n_f, n_log;
    logic beat;
    for (int k = 0; k < sc.n; k++)
      w.push_back(sc.mode == 1 ? 32'h00021020 + k : sc.mode == 2 ? (k == 0 ? 32'hAAAA0000 : 32'h1) : $urandom);
    for (int k = 0; k < acc; k++) exp_sum += w[k];
    @(posedge clk); #1;
    sel = sc.b;
    if (sc.b) start_b = 1; else start_a = 1;
    @(posedge clk); #1;
    start_a = 0; start_b = 0;
    base_w = log_q.size();
    base_f = fall_q.size();
    @(negedge clk);
    chk("entry cpu_rst", cr_m, 1);
    chk("entry busy", busy_m, 1);
    chk("entry done", done_m, 0);
    chk("entry error", err_m, 0);
    chk("entry word_count", cnt_m, 0);
    chk("entry checksum", sum_m, 0);
    while (i < sc.n && cycles < 4 * sc.n + 8) begin
      if (sc.gap && cycles % 2 == 1) begin
        s_valid = 0; s_data = $urandom; s_last = 1'($urandom);
      end else begin
        s_valid = 1; s_data = w[i]; s_last = sc.last && i == sc.n - 1;
      end
      chk("s_ready", rdy_m, i < acc);
      beat = s_valid && rdy_m;
      @(posedge clk);
      if (beat) i++;
      @(negedge clk);
      cycles++;
    end
    s_valid = 0; s_last = 0;
    chk("words accepted", i, acc);
    repeat (rd + 3) @(negedge clk);
    n_wr = log_q.size() - base_w;
    n_f = fall_q.size() - base_f;
    chk("write count", n_wr, acc);
    if (n_wr == acc) begin
      for (int k = 0; k < acc; k++) begin
        chk("write addr", log_q[base_w + k].a, 4 * k);
        chk("write data", log_q[base_w + k].d, w[k]);
      end
      if (!sc.gap) chk("back-to-back writes", log_q[base_w + acc - 1].c - log_q[base_w].c, acc - 1);
    end
    chk("word_count", cnt_m, acc);
    chk("checksum", sum_m, exp_sum);
    chk("busy after", busy_m, 0);
    chk("s_ready after", rdy_m, 0);
    chk("error", err_m, ovf);
    chk("done", done_m, !ovf);
    chk("cpu_rst", cr_m, ovf);
    chk("cpu_rst falls", n_f, !ovf);
    if (!ovf && n_f == 1 && n_wr == acc)
      chk("release delay", fall_q[base_f] - log_q[base_w + acc - 1].c, rd);
    if (sc.chk_tab) begin
      chk("table word_count", cnt_m, sc.exp_cnt);
      chk("table error", err_m, sc.exp_err);
    end
    if (sc.chk_sum) chk("table checksum", sum_m, sc.exp_sum);
    n_log = log_q.size();
    s_valid = 1; s_last = 1;
    repeat (3) begin
      s_data = $urandom;
      @(negedge clk);
    end
    s_valid = 0; s_last = 0;
    chk("idle valid ignored writes", log_q.size(), n_log);
    chk("idle valid ignored count", cnt_m, acc);
  endtask

  initial begin
    scen_t sc;
    tab[0] = '{0, 8, 1, 0, 1, 1, 8, 0, 32'h0010811C, 1};
    tab[1] = '{0, 2, 2, 0, 1, 1, 2, 0, 32'hAAAA0001, 1};
    tab[2] = '{0, 6, 0, 1, 1, 1, 6, 0, 32'h0, 0};
    tab[3] = '{1, 5, 1, 0, 0, 1, 4, 1, 32'h00084086, 1};
    tab[4] = '{1, 3, 0, 1, 1, 1, 3, 0, 32'h0, 0};
    tab[5] = '{0, 64, 0, 0, 1, 1, 64, 0, 32'h0, 0};
    tab[6] = '{1, 4, 0, 1, 1, 1, 4, 0, 32'h0, 0};
    tab[7] = '{0, 1, 0, 0, 1, 1, 1, 0, 32'h0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cpu_rst", cr_a, 1);
    chk("reset initialize", init_a, 0);
    chk("reset s_ready", rdy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset error", err_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset word_count", cnt_a, 0);
    chk("reset checksum", sum_a, 0);
    chk("reset data", d_a, 0);
    chk("reset addr", ad_a, 0);
    chk("reset cpu_rst b", cr_b, 1);
    chk("reset s_ready b", rdy_b, 0);
    rst = 0;
    s_valid = 1; s_data = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    s_valid = 0;
    chk("idle ignores valid", log_q.size(), 0);
    chk("idle count", cnt_a, 0);
    for (int t = 0; t < 8; t++) run_case(tab[t]);
    @(posedge clk); #1;
    sel = 0; start_a = 1;
    @(posedge clk); #1;
    start_a = 0; s_valid = 1;
    repeat (3) begin
      s_data = $urandom;
      @(posedge clk); #1;
    end
    s_valid = 0;
    chk("mid-load count", cnt_a, 3);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst mid-load count", cnt_a, 0);
    chk("rst mid-load cpu_rst", cr_a, 1);
    chk("rst mid-load busy", busy_a, 0);
    chk("rst mid-load s_ready", rdy_a, 0);
    chk("rst mid-load checksum", sum_a, 0);
    sc = '{0, 5, 0, 0, 1, 1, 5, 0, 32'h0, 0};
    run_case(sc);
    for (int r = 0; r < 6; r++) begin
      sc.b = 1'($urandom_range(0, 1));
      sc.last = sc.b ? 1'($urandom_range(0, 1)) : 1'b1;
      sc.n = sc.b ? (sc.last ? int'($urandom_range(1, 4)) : int'($urandom_range(4, 6))) : int'($urandom_range(1, 20));
      sc.mode = 0;
      sc.gap = 1'($urandom_range(0, 1));
      sc.chk_tab = 0;
      sc.chk_sum = 0;
      run_case(sc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
